// File: rtl/fp21_pkg.sv
// fp21_pkg: shared FP21 definitions for the FP21 <-> integer conversion paths.
//   - field widths, bias and the all-ones exponent code
//   - packed FP21 operand layout {sign, exp, frac}
//   - operand classification used by the FP21-to-integer pipeline
//   - bit positions inside the 3-bit {invalid, overflow, inexact} flag vector
package fp21_pkg;

  localparam int FP21_W      = 21;
  localparam int EXP_W       = 7;
  localparam int FRAC_W      = 13;
  localparam int FP21_BIAS   = 63;
  localparam int EXP_SPECIAL = 127;

  localparam int FLAG_INVALID  = 2;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_INEXACT  = 0;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp21_t;

  typedef enum logic [2:0] {
    CLS_ZERO,    // exp == 0: zero or flushed denormal
    CLS_NAN,     // exp all-ones, frac != 0
    CLS_INF,     // exp all-ones, frac == 0
    CLS_UNDER,   // |x| < 1
    CLS_OVF,     // |x| >= 2^15 (saturates)
    CLS_NORM,    // in range, goes through the shifter
    CLS_NEGMAX   // exactly -2^15, representable without saturation
  } fp21_class_e;

endpackage

// File: rtl/fp21_to_int16_if.sv
// fp21_to_int16_if: valid/ready streaming bus of the FP21-to-int16 converter.
//   in_valid/in_ready/in_data   : FP21 operand stream into the converter
//   out_valid/out_ready         : result stream out of the converter
//   out_data                    : signed 16-bit integer result
//   out_flags                   : {invalid, overflow, inexact}
// slave  = converter side, master = producer/consumer side.
interface fp21_to_int16_if;
  import fp21_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [FP21_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic [2:0]        out_flags;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/fp21_int_shifter.sv
// fp21_int_shifter: combinational bidirectional barrel shifter.
//   m_i      : 14-bit significand {1, frac}
//   left_i   : 1 = shift left, 0 = shift right
//   amt_i    : shift amount
//   mag_o    : 16-bit shifted magnitude
//   sticky_o : OR of the bits shifted out on a right shift (0 on a left shift)
module fp21_int_shifter
  import fp21_pkg::*;
(
  input  logic [FRAC_W:0] m_i,
  input  logic            left_i,
  input  logic [3:0]      amt_i,
  output logic [15:0]     mag_o,
  output logic            sticky_o
);

  logic [15:0] ext;
  logic [15:0] mask;

  always_comb begin
    ext  = {2'b00, m_i};
    mask = (16'd1 << amt_i) - 16'd1;
    if (left_i) begin
      mag_o    = ext << amt_i;
      sticky_o = 1'b0;
    end else begin
      mag_o    = ext >> amt_i;
      sticky_o = |(ext & mask);
    end
  end

endmodule

// File: rtl/fp21_to_int16.sv
// fp21_to_int16: 3-stage FP21 to signed 16-bit integer converter.
// Truncates toward zero, saturates on overflow, flags {invalid, overflow, inexact}.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : fp21_to_int16_if.slave (in_valid/in_ready/in_data,
//          out_valid/out_ready/out_data/out_flags)
// A single enable (!out_valid || out_ready) advances every stage at once, so a
// stalled output freezes the whole pipe and in_ready follows it combinationally.
module fp21_to_int16
  import fp21_pkg::*;
#(
  parameter int OUT_W = 16,
  parameter int BIAS  = FP21_BIAS
)(
  input  logic              clk,
  input  logic              rst,
  fp21_to_int16_if.slave    bus
);

  localparam logic signed [8:0] BIAS_S = 9'(BIAS);

  logic                    en;
  fp21_t                   op;
  logic signed [8:0]       e;

  logic                    vld_p1_q, vld_p2_q, vld_p3_q;
  logic                    vld_p1_d, vld_p2_d, vld_p3_d;

  fp21_class_e             cls_p1_d, cls_p1_q, cls_p2_q;
  logic                    sign_p1_d, sign_p1_q, sign_p2_q;
  logic [FRAC_W:0]         m_p1_d, m_p1_q;
  logic                    left_p1_d, left_p1_q;
  logic [3:0]              amt_p1_d, amt_p1_q;

  logic [OUT_W-1:0]        mag_p2_d, mag_p2_q;
  logic                    sticky_p2_d, sticky_p2_q;

  logic signed [OUT_W-1:0] data_p3_d, data_p3_q;
  logic [2:0]              flags_p3_d, flags_p3_q;

  function automatic logic signed [OUT_W-1:0] sat_limit(input logic neg);
    sat_limit = neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  function automatic logic signed [OUT_W-1:0] apply_sign(input logic neg,
                                                         input logic [OUT_W-1:0] mag);
    apply_sign = neg ? -$signed(mag) : $signed(mag);
  endfunction

  assign en           = !vld_p3_q || bus.out_ready;
  assign bus.in_ready = en && !rst;
  assign op           = fp21_t'(bus.in_data);

  // ---- S1: unpack, classify, shift amount ----
  always_comb begin
    e         = $signed({2'b00, op.exp}) - BIAS_S;
    sign_p1_d = op.sign;
    m_p1_d    = {1'b1, op.frac};
    cls_p1_d  = CLS_NORM;
    left_p1_d = 1'b0;
    amt_p1_d  = 4'(9'sd13 - e);
    if (op.exp == '0) begin
      cls_p1_d = CLS_ZERO;
    end else if (op.exp == EXP_W'(EXP_SPECIAL)) begin
      cls_p1_d = (op.frac != '0) ? CLS_NAN : CLS_INF;
    end else if (e < 9'sd0) begin
      cls_p1_d = CLS_UNDER;
    end else if (e == 9'sd14) begin
      left_p1_d = 1'b1;
      amt_p1_d  = 4'd1;
    end else if (e >= 9'sd15) begin
      // -2^15 is the one value with e == 15 that fits in 16 bits
      cls_p1_d = (e == 9'sd15 && op.sign && op.frac == '0) ? CLS_NEGMAX : CLS_OVF;
    end
  end

  // ---- S2: shift and sticky ----
  fp21_int_shifter u_shifter (
    .m_i      (m_p1_q),
    .left_i   (left_p1_q),
    .amt_i    (amt_p1_q),
    .mag_o    (mag_p2_d),
    .sticky_o (sticky_p2_d)
  );

  // ---- S3: negate / saturate ----
  always_comb begin
    data_p3_d  = '0;
    flags_p3_d = '0;
    case (cls_p2_q)
      CLS_ZERO:   data_p3_d = '0;
      CLS_NAN:    flags_p3_d[FLAG_INVALID] = 1'b1;
      CLS_INF,
      CLS_OVF: begin
        data_p3_d                 = sat_limit(sign_p2_q);
        flags_p3_d[FLAG_OVERFLOW] = 1'b1;
      end
      CLS_UNDER:  flags_p3_d[FLAG_INEXACT] = 1'b1;
      CLS_NEGMAX: data_p3_d = sat_limit(1'b1);
      CLS_NORM: begin
        data_p3_d                = apply_sign(sign_p2_q, mag_p2_q);
        flags_p3_d[FLAG_INEXACT] = sticky_p2_q;
      end
      default: begin
        data_p3_d  = '0;
        flags_p3_d = '0;
      end
    endcase
  end

  always_comb begin
    vld_p1_d = en ? bus.in_valid : vld_p1_q;
    vld_p2_d = en ? vld_p1_q     : vld_p2_q;
    vld_p3_d = en ? vld_p2_q     : vld_p3_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      vld_p3_q   <= 1'b0;
      data_p3_q  <= '0;
      flags_p3_q <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
      if (en) begin
        data_p3_q  <= data_p3_d;
        flags_p3_q <= flags_p3_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      sign_p1_q   <= sign_p1_d;
      cls_p1_q    <= cls_p1_d;
      m_p1_q      <= m_p1_d;
      left_p1_q   <= left_p1_d;
      amt_p1_q    <= amt_p1_d;
      sign_p2_q   <= sign_p1_q;
      cls_p2_q    <= cls_p1_q;
      mag_p2_q    <= mag_p2_d;
      sticky_p2_q <= sticky_p2_d;
    end
  end

  assign bus.out_valid = vld_p3_q;
  assign bus.out_data  = data_p3_q;
  assign bus.out_flags = flags_p3_q;

endmodule

// File: tb/tb_fp21_to_int16.sv
// tb_fp21_to_int16: self-checking bench for fp21_to_int16.
// Directed vector table, backpressure and mid-stream reset sequences, and a
// throttled random sweep, all checked through an in-order scoreboard queue.
module tb_fp21_to_int16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp21_to_int16_if bus();

  fp21_to_int16 #(.OUT_W(16), .BIAS(63)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [20:0] din;
    logic [15:0] d;
    logic [2:0]  f;
  } vec_t;

  typedef struct {
    logic [20:0] din;
    logic [15:0] d;
    logic [2:0]  f;
    int          acc_tick;
    bit          chk_lat;
  } sb_t;

  int          checks   = 0;
  int          failures = 0;
  int          tick_no  = 0;
  bit          lat_mode = 1'b0;
  bit          held     = 1'b0;
  logic [15:0] held_d;
  logic [2:0]  held_f;
  sb_t         sbq[$];
  vec_t        tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", name, act, exp, tick_no);
    end
  endtask

  // Reference: value scaled by 2^13 as an integer, truncated back down.
  function automatic void ref_model(input logic [20:0] x, output logic [15:0] d,
                                    output logic [2:0] f);
    logic   s;
    int     ex, fr, e;
    longint m, sc, mag;
    logic [15:0] sat;
    s   = x[20];
    ex  = int'(x[19:13]);
    fr  = int'(x[12:0]);
    e   = ex - 63;
    sat = s ? 16'h8000 : 16'h7FFF;
    d   = 16'h0000;
    f   = 3'b000;
    if (ex == 0) begin
      d = 16'h0000;
    end else if (ex == 127) begin
      if (fr != 0) f = 3'b100;
      else begin d = sat; f = 3'b010; end
    end else if (e < 0) begin
      f = 3'b001;
    end else if (e >= 16) begin
      d = sat; f = 3'b010;
    end else begin
      m   = longint'(8192 + fr);
      sc  = m << e;
      mag = sc >>> 13;
      if (mag > 32767 && !(s && mag == 32768 && (sc & 8191) == 0)) begin
        d = sat; f = 3'b010;
      end else begin
        d = s ? 16'(-mag) : 16'(mag);
        if ((sc & 8191) != 0) f = 3'b001;
      end
    end
  endfunction

  // One clock cycle: called at posedge+1, drives, samples mid-cycle, waits the edge.
  task automatic tick(input bit vin, input logic [20:0] din, input logic [15:0] ed,
                      input logic [2:0] ef, input bit ordy, output bit acc);
    sb_t e;
    sb_t got;
    bus.in_valid  = vin;
    bus.in_data   = din;
    bus.out_ready = ordy;
    #4;
    chk("in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
    if (held) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_data", 32'(bus.out_data), 32'(held_d));
      chk("hold_flags", 32'(bus.out_flags), 32'(held_f));
    end
    held   = bus.out_valid && !bus.out_ready;
    held_d = bus.out_data;
    held_f = bus.out_flags;
    if (bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %h/%b with nothing pending (tick %0d)",
                 bus.out_data, bus.out_flags, tick_no);
      end else begin
        got = sbq.pop_front();
        chk("data", 32'(bus.out_data), 32'(got.d));
        chk("flags", 32'(bus.out_flags), 32'(got.f));
        if (got.chk_lat) chk("latency", 32'(tick_no - got.acc_tick), 32'd3);
      end
    end
    acc = vin && bus.in_ready;
    if (acc) begin
      e.din = din; e.d = ed; e.f = ef; e.acc_tick = tick_no; e.chk_lat = lat_mode;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    tick_no++;
  endtask

  task automatic drain(input int bound);
    bit acc;
    for (int k = 0; k < bound && sbq.size() > 0; k++) tick(1'b0, 21'h0, 16'h0, 3'b0, 1'b1, acc);
    chk("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int          idx;
    logic [20:0] x;
    logic [15:0] md;
    logic [2:0]  mf;
    bit          vin, ordy;

    tbl.push_back('{21'h07E000, 16'h0001, 3'b000});  // 1.0
    tbl.push_back('{21'h080800, 16'h0002, 3'b001});  // 2.5
    tbl.push_back('{21'h19C000, 16'h8000, 3'b000});  // -32768 exact
    tbl.push_back('{21'h09C000, 16'h7FFF, 3'b010});  // +32768 overflow
    tbl.push_back('{21'h0FE001, 16'h0000, 3'b100});  // NaN
    tbl.push_back('{21'h1FE000, 16'h8000, 3'b010});  // -Inf
    tbl.push_back('{21'h07C000, 16'h0000, 3'b001});  // 0.5
    tbl.push_back('{21'h000123, 16'h0000, 3'b000});  // denormal
    tbl.push_back('{21'h180800, 16'hFFFE, 3'b001});  // -2.5
    tbl.push_back('{21'h0FE000, 16'h7FFF, 3'b010});  // +Inf
    tbl.push_back('{21'h09BFFF, 16'h7FFE, 3'b000});  // e=14, max frac
    tbl.push_back('{21'h19BFFF, 16'h8002, 3'b000});  // negative of above
    tbl.push_back('{21'h19C001, 16'h8000, 3'b010});  // e=15 sign=1 frac!=0
    tbl.push_back('{21'h100000, 16'h0000, 3'b000});  // -0
    tbl.push_back('{21'h17C000, 16'h0000, 3'b001});  // -0.5
    tbl.push_back('{21'h07F000, 16'h0001, 3'b001});  // 1.5
    tbl.push_back('{21'h098ABC, 16'h2ABC, 3'b000});  // e=13 exact

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Directed table, streaming back-to-back with no stalls
    lat_mode = 1'b1;
    foreach (tbl[i]) begin
      tick(1'b1, tbl[i].din, tbl[i].d, tbl[i].f, 1'b1, acc);
      chk("table_accept", 32'(acc), 32'd1);
    end
    drain(20);

    // 8 back-to-back operands, output stalled for cycles 4..7
    lat_mode = 1'b0;
    idx = 0;
    for (int t = 0; t < 40 && idx < 8; t++) begin
      tick(1'b1, tbl[idx].din, tbl[idx].d, tbl[idx].f, !(t >= 4 && t <= 7), acc);
      if (acc) idx++;
    end
    chk("bp_all_accepted", 32'(idx), 32'd8);
    drain(20);

    // Reset with three operands in flight
    for (int i = 0; i < 3; i++) tick(1'b1, tbl[i].din, tbl[i].d, tbl[i].f, 1'b1, acc);
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_async_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_async_out_data", 32'(bus.out_data), 32'd0);
    sbq.delete();
    held = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);
    lat_mode = 1'b1;
    tick(1'b1, 21'h080800, 16'h0002, 3'b001, 1'b1, acc);
    chk("post_rst_accept", 32'(acc), 32'd1);
    drain(20);
    for (int k = 0; k < 6; k++) tick(1'b0, 21'h0, 16'h0, 3'b0, 1'b1, acc);

    // Random sweep with input and output throttling
    lat_mode = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      x[20]    = 1'($urandom_range(0, 1));
      x[19:13] = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(48, 80))
                                             : 7'($urandom_range(0, 127));
      x[12:0]  = 13'($urandom_range(0, 8191));
      ref_model(x, md, mf);
      vin  = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      tick(vin, x, md, mf, ordy, acc);
    end
    drain(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp21_to_int16.md
# fp21_to_int16

Pipelined FP21-to-signed-16-bit-integer converter for the FP21 arithmetic cores. It is the decode direction of the integer normalisation path. The encode side counts leading zeros and left-shifts an integer into FP21; this block takes an exponent and right- or left-shifts the significand back into a two's-complement integer. Rounding truncates toward zero, and overflow saturates. It has a 3-stage pipeline with valid/ready handshakes on both sides, and feeds pixel/coordinate quantisation in the path tracer.

## Interface
- `OUT_W`, default 16: integer output width. Only 16 is supported.
- `BIAS`, default 63: FP21 exponent bias.
- `clk`  input  1: clock. All state changes on its rising edge.
- `rst`  input  1: reset. Asynchronous and active-high.
- `in_valid`  input  1: `in_data` is valid.
- `in_ready`  output  1: the block accepts input this cycle.
- `in_data`  input  21: FP21 operand: [20] sign, [19:13] exponent, [12:0] fraction.
- `out_valid`  output  1: `out_data` and `out_flags` are valid.
- `out_ready`  input  1: the consumer accepts output this cycle.
- `out_data`  output  16: signed integer result.
- `out_flags`  output  3: {invalid, overflow, inexact}.

## Operation
- **Decode:** `e = exp - BIAS`; significand `m = {1, frac}` (14 bits).
- **Zero/denormal** (`exp == 0`): result 0, no flags. Denormals are flushed and negative zero gives 0.
- **`exp == 127`, `frac != 0` (NaN):** result 0, invalid=1.
- **`exp == 127`, `frac == 0` (±Inf):** saturate (+32767 / −32768), overflow=1.
- **`e < 0`:** result 0, inexact=1.
- **`0 <= e <= 13`:** `mag = m >> (13 - e)`. inexact = OR of the shifted-out bits.
- **`e == 14`:** `mag = m << 1`; exact.
- **`e >= 15`:** overflow. One exception: `sign=1`, `e=15`, `frac=0` gives −32768 exactly, no flag. Otherwise saturate to +32767 (sign 0) or −32768 (sign 1), overflow=1, inexact=0.
- **Negation:** in-range results with sign=1 are negated (two's complement). Magnitude at most 32767 for `e <= 14`, so negation never overflows.
- **Flag exclusivity:** at most one flag is set per result.

## Timing
- **Latency:** exactly 3 cycles from the accepting edge (`in_valid && in_ready`) to `out_valid`, with no stalls.
- **Throughput:** 1 result/cycle while `out_ready` is held high.
- **Stall rule:** global enable `en = !out_valid || out_ready`; `in_ready = en`, combinational.
  - When `en` is 0, all three stages hold their contents and no data is lost or duplicated.
  - Bubbles propagate as stage-valid = 0.
- **Output stability:** `out_data` and `out_flags` stay stable while `out_valid && !out_ready`.
- **Handshake independence:** `in_valid` may toggle freely and is sampled only when `in_ready = 1`.
- **Reset** (async assert, synchronous-safe release):
  - all stage-valid bits = 0, `out_valid` = 0, `out_data` = 0, `out_flags` = 0;
  - `in_ready` = 0 while `rst` is high and 1 in the first cycle after release;
  - reset mid-stream discards all in-flight operands, and no output appears for them after release.
- **Stages:**
  - S1: unpack, classify (zero/NaN/Inf/underflow/overflow/normal), compute shift amount.
  - S2: shift and sticky (inexact) generation.
  - S3: negate/saturate, register outputs.

## Structure
- **`fp21_pkg`:** `FP21_W`=21, `EXP_W`=7, `FRAC_W`=13, `FP21_BIAS`=63, `EXP_SPECIAL`=127, the packed FP21 field typedef (sign/exp/frac), the operand-class enum, and flag bit indices (`FLAG_INVALID`=2, `FLAG_OVERFLOW`=1, `FLAG_INEXACT`=0). Shared with the LZC-based integer-to-FP21 path.
- **`fp21_int_shifter`:** one sub-module. Combinational 14-bit-in, 16-bit-out bidirectional barrel shifter with sticky output, instantiated in S2.

## Test plan
- **1.0, then 2.5:** `21'h07E000` → `16'd1`, flags 000; `21'h080800` (2.5) → `16'd2`, flags 001. Both appear exactly 3 cycles after acceptance.
- **Exact negative limit, then overflow:** `21'h19C000` (−32768) → `16'h8000`, flags 000; `21'h09C000` (+32768) → `16'h7FFF`, flags 010.
- **Specials and underflow:**
  - `21'h0FE001` (NaN) → 0, flags 100;
  - `21'h1FE000` (−Inf) → `16'h8000`, flags 010;
  - `21'h07C000` (0.5) → 0, flags 001;
  - `21'h000123` (denormal) → 0, flags 000.
- **Back-to-back with backpressure:** 8 consecutive inputs with `out_ready` = 0 for cycles 4–7. Required: all 8 results emerge in order with no loss or duplication, output held stable during the stall, and `in_ready` low while the output is stalled.
- **Reset mid-operation:** 3 operands in flight, then `rst` pulsed asynchronously between edges. Required: `out_valid` drops immediately and no stale results appear after release. `in_ready` = 1 one cycle after release, and the next operand returns its correct result 3 cycles later.
- **Random sweep:** 10k random FP21 inputs checked against a reference model (truncate, saturate, flags) with random `out_ready` throttling.
